// File: rtl/key_pkg.sv
// Shared key-matrix definitions: sizes, press-sequence states and index decoding.
// Also used by the key_scan side of the loopback.
package key_pkg;

    localparam int KEY_NUM = 20;
    localparam int COL_W   = 4;
    localparam int ROW_W   = 5;
    localparam int KEY_W   = 5;
    localparam int COL_IW  = $clog2(COL_W);
    localparam int ROW_IW  = $clog2(ROW_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } key_state_t;

    typedef struct packed {
        logic [COL_IW-1:0] col;
        logic [ROW_IW-1:0] row;
    } key_pos_t;

    // Keys are numbered column-major: five rows per column.
    function automatic key_pos_t key_to_pos(input logic [KEY_W-1:0] key);
        key_pos_t pos;
        pos.col = COL_IW'(key / KEY_W'(ROW_W));
        pos.row = ROW_IW'(key % KEY_W'(ROW_W));
        return pos;
    endfunction

    function automatic logic key_valid(input logic [KEY_W-1:0] key);
        return key < KEY_W'(KEY_NUM);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the scanner's active-low column strobes.
// Resets to all-ones so no column looks strobed after reset.
module sync_2ff
    import key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] d,
    output logic [COL_W-1:0] q
);

    logic [COL_W-1:0] meta;

    // Shift the asynchronous strobes through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_inject.sv
// Simulates a key press on a scanned matrix: answers the scanner's column
// strobe on the selected row for a bounce/hold period, then stays quiet for a gap.
module key_inject
    import key_pkg::*;
#(
    parameter int HOLD_MS  = 50,
    parameter int GAP_MS   = 50,
    parameter int BOUNCE_N = 0
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             pls1k,
    input  logic             req_vld,
    input  logic [KEY_W-1:0] req_key,
    output logic             req_rdy,
    output logic             req_err,
    input  logic             abort,
    input  logic [COL_W-1:0] key_column_in,
    output logic [ROW_W-1:0] key_row_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(GAP_MS);
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_N);

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key_lat;
    logic             pressed;
    logic             pls_q;
    logic             pls_q2;
    logic             tick;
    logic [COL_W-1:0] col_sync;
    key_pos_t         key_pos;
    logic [ROW_W-1:0] row_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_column_in),
        .q   (col_sync)
    );

    // Register pls1k twice so a long-high pulse gives a single tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pls_q  <= 1'b0;
            pls_q2 <= 1'b0;
        end else begin
            pls_q  <= pls1k;
            pls_q2 <= pls_q;
        end
    end

    assign tick    = pls_q & ~pls_q2;
    assign key_pos = key_to_pos(key_lat);

    // Press sequencer: accept a request, then bounce, hold and gap on ms ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            key_lat <= '0;
            pressed <= 1'b0;
            req_rdy <= 1'b0;
            req_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            req_err <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_vld && req_rdy) begin
                        if (key_valid(req_key)) begin
                            key_lat <= req_key;
                            cnt     <= '0;
                            pressed <= 1'b1;
                            req_rdy <= 1'b0;
                            busy    <= 1'b1;
                            state   <= (BOUNCE_N > 0) ? ST_BOUNCE : ST_HOLD;
                        end else begin
                            req_err <= 1'b1;
                            req_rdy <= 1'b1;
                        end
                    end else begin
                        req_rdy <= 1'b1;
                    end
                end
                ST_BOUNCE: begin
                    if (abort) begin
                        state   <= ST_GAP;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else if (tick) begin
                        if (cnt + CNT_W'(1) == BOUNCE_LIM) begin
                            state   <= ST_HOLD;
                            cnt     <= '0;
                            pressed <= 1'b1;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            pressed <= ~pressed;
                        end
                    end
                end
                ST_HOLD: begin
                    if (abort || cnt == HOLD_LIM) begin
                        state   <= ST_GAP;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else if (tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LIM) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pull the latched row low only while pressed and its column is strobed.
    always_comb begin
        row_next = '1;
        if (pressed && !col_sync[key_pos.col]) begin
            row_next[key_pos.row] = 1'b0;
        end
    end

    // Registered row return; reset releases the key immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_row_out <= '1;
        end else begin
            key_row_out <= row_next;
        end
    end

endmodule

// File: tb/tb_key_inject.sv
// Self-checking bench for key_inject: directed press sequences plus random
// traffic, compared every cycle against a phase/tick-count model of the press.
module tb_key_inject;

    localparam int HOLD_T   = 5;
    localparam int GAP_T    = 3;
    localparam int BOUNCE_T = 3;

    localparam int P_IDLE   = 0;
    localparam int P_BOUNCE = 1;
    localparam int P_HOLD   = 2;
    localparam int P_GAP    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pls1k = 1'b0;
    logic       req_vld = 1'b0;
    logic [4:0] req_key = 5'd0;
    logic       abort = 1'b0;
    logic [3:0] key_column_in = 4'hF;
    logic       req_rdy;
    logic       req_err;
    logic       busy;
    logic       done;
    logic [4:0] key_row_out;

    int n_vec = 0;
    int n_fail = 0;
    int done_cnt = 0;

    // Model state: phase, ticks counted in it, latched key, input history.
    int         m_phase;
    int         m_ticks;
    int         m_key;
    bit         m_p1;
    bit         m_p2;
    logic [3:0] m_c1;
    logic [3:0] m_c2;
    logic [4:0] exp_row;
    logic       exp_rdy;
    logic       exp_err;
    logic       exp_busy;
    logic       exp_done;

    always #50 clk = ~clk;

    key_inject #(
        .HOLD_MS  (HOLD_T),
        .GAP_MS   (GAP_T),
        .BOUNCE_N (BOUNCE_T)
    ) dut (
        .rst           (rst),
        .clk           (clk),
        .pls1k         (pls1k),
        .req_vld       (req_vld),
        .req_key       (req_key),
        .req_rdy       (req_rdy),
        .req_err       (req_err),
        .abort         (abort),
        .key_column_in (key_column_in),
        .key_row_out   (key_row_out),
        .busy          (busy),
        .done          (done)
    );

    task automatic check_output(input string name, input logic [4:0] act, input logic [4:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_ticks  = 0;
        m_key    = 0;
        m_p1     = 1'b0;
        m_p2     = 1'b0;
        m_c1     = 4'hF;
        m_c2     = 4'hF;
        exp_row  = 5'h1F;
        exp_rdy  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_enter(input int phase);
        m_phase = phase;
        m_ticks = 0;
    endtask

    // The key is down for the whole hold and on even tick counts while bouncing.
    function automatic bit model_pressed();
        if (m_phase == P_HOLD) return 1'b1;
        if (m_phase == P_BOUNCE) return (m_ticks % 2) == 0;
        return 1'b0;
    endfunction

    // Predict outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit         tick;
        logic [4:0] row_n;
        tick  = m_p1 && !m_p2;
        row_n = 5'h1F;
        if (model_pressed() && !m_c2[m_key / 5]) row_n[m_key % 5] = 1'b0;
        m_p2 = m_p1;
        m_p1 = pls1k;
        m_c2 = m_c1;
        m_c1 = key_column_in;
        exp_row  = row_n;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (req_vld && exp_rdy) begin
                    if (int'(req_key) < 20) begin
                        m_key   = int'(req_key);
                        exp_rdy = 1'b0;
                        model_enter(BOUNCE_T > 0 ? P_BOUNCE : P_HOLD);
                    end else begin
                        exp_err = 1'b1;
                    end
                end else begin
                    exp_rdy = 1'b1;
                end
            end
            P_BOUNCE: begin
                if (abort) model_enter(P_GAP);
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == BOUNCE_T) model_enter(P_HOLD);
                end
            end
            P_HOLD: begin
                if (abort || m_ticks == HOLD_T) model_enter(P_GAP);
                else if (tick) m_ticks++;
            end
            default: begin
                if (m_ticks == GAP_T) begin
                    model_enter(P_IDLE);
                    exp_done = 1'b1;
                end else if (tick) m_ticks++;
            end
        endcase
        exp_busy = (m_phase != P_IDLE);
    endtask

    task automatic apply_stimulus(input logic rv, input logic vld, input logic [4:0] key,
                                  input logic pv, input logic av, input logic [3:0] cv);
        @(negedge clk);
        rst           = rv;
        req_vld       = vld;
        req_key       = key;
        pls1k         = pv;
        abort         = av;
        key_column_in = cv;
        if (rv) model_reset();
        else model_step();
    endtask

    // One ms tick: pls1k high for two clocks, then low long enough to settle.
    task automatic run_ticks(input int n, input logic [3:0] cv);
        for (int t = 0; t < n; t++) begin
            apply_stimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, cv);
            apply_stimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, cv);
            for (int j = 0; j < 4; j++) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, cv);
        end
    endtask

    task automatic press_key(input logic [4:0] key, input logic [3:0] cv);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b1, key, 1'b0, 1'b0, cv);
            @(posedge clk);
            #10;
            if (busy === 1'b1) break;
        end
        check_output("press_accepted", 5'(busy), 5'd1);
    endtask

    // Compare every output with the model shortly after each active edge.
    always @(posedge clk) begin
        #10;
        check_output("req_rdy", 5'(req_rdy), 5'(exp_rdy));
        check_output("req_err", 5'(req_err), 5'(exp_err));
        check_output("busy", 5'(busy), 5'(exp_busy));
        check_output("done", 5'(done), 5'(exp_done));
        check_output("key_row_out", key_row_out, exp_row);
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        int         d0;
        int         hi_left;
        int         lo_left;
        logic       pv;
        logic [3:0] cv;
        logic       rv;

        model_reset();
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'hF);
        check_output("reset_row", key_row_out, 5'h1F);
        check_output("reset_rdy", 5'(req_rdy), 5'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'hF);
        @(posedge clk); #10;
        check_output("rdy_after_reset", 5'(req_rdy), 5'd1);

        // Out-of-range index is refused with a one-clock error pulse.
        apply_stimulus(1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 4'b0000);
        @(posedge clk); #10;
        check_output("invalid_err", 5'(req_err), 5'd1);
        check_output("invalid_busy", 5'(busy), 5'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk); #10;
        check_output("invalid_err_clear", 5'(req_err), 5'd0);
        check_output("invalid_row", key_row_out, 5'h1F);

        // Key 7 is column 1, row 2; bounce pattern low/high/low, then held low.
        press_key(5'd7, 4'b1101);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101);
        check_output("bounce_start_row", key_row_out, 5'h1B);
        apply_stimulus(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'b1101);
        @(posedge clk); #10;
        check_output("busy_rdy_low", 5'(req_rdy), 5'd0);
        run_ticks(1, 4'b1101);
        check_output("bounce_tick1_row", key_row_out, 5'h1F);
        run_ticks(1, 4'b1101);
        check_output("bounce_tick2_row", key_row_out, 5'h1B);
        run_ticks(1, 4'b1101);
        check_output("hold_row", key_row_out, 5'h1B);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1011);
        check_output("other_column_row", key_row_out, 5'h1F);
        run_ticks(HOLD_T, 4'b1101);
        check_output("gap_row", key_row_out, 5'h1F);
        d0 = done_cnt;
        run_ticks(GAP_T, 4'b1101);
        check_output("done_once", 5'(done_cnt - d0), 5'd1);

        // Abort two ticks into the hold releases the key and still runs the gap.
        press_key(5'd7, 4'b1101);
        run_ticks(BOUNCE_T + 2, 4'b1101);
        check_output("pre_abort_row", key_row_out, 5'h1B);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1101);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1101);
        check_output("abort_row", key_row_out, 5'h1F);
        d0 = done_cnt;
        run_ticks(GAP_T, 4'b1101);
        check_output("abort_done", 5'(done_cnt - d0), 5'd1);

        // Reset in the middle of the hold releases the key at once.
        press_key(5'd19, 4'b0111);
        run_ticks(BOUNCE_T + 1, 4'b0111);
        check_output("pre_reset_row", key_row_out, 5'h0F);
        d0 = done_cnt;
        @(negedge clk);
        #20 rst = 1'b1;
        model_reset();
        #1;
        check_output("async_reset_row", key_row_out, 5'h1F);
        apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0111);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0111);
        @(posedge clk); #10;
        check_output("reset_release_rdy", 5'(req_rdy), 5'd1);
        check_output("reset_no_done", 5'(done_cnt - d0), 5'd0);

        // Random traffic against the model.
        hi_left = 0;
        lo_left = 0;
        cv = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if (hi_left > 0) begin
                pv = 1'b1;
                hi_left--;
            end else if (lo_left > 0) begin
                pv = 1'b0;
                lo_left--;
            end else begin
                pv = 1'b1;
                hi_left = $urandom_range(0, 3);
                lo_left = $urandom_range(3, 9);
            end
            if ($urandom_range(0, 3) == 0) cv = 4'($urandom);
            rv = ($urandom_range(0, 499) == 0);
            apply_stimulus(rv, 1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 23)),
                           pv, 1'($urandom_range(0, 29) == 0), cv);
        end
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, cv);
        @(posedge clk); #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
